value_text_writer: RTL and testbench
====================================

VALUE_TEXT_WRITER -- requirements
Module: value_text_writer

Interface
REQ-001 SHALL have parameter LOWERCASE_HEX, default 0; 1 selects hex digits "a"-"f", 0 selects "A"-"F".
REQ-002 SHALL have parameter SEP_CHAR, default 8'h5F ("_"); this is the byte-group separator in binary format.
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-005 SHALL have port start  input  1  request to render one value; sampled only when busy=0.
REQ-006 SHALL have port value  input  16  value to render.
REQ-007 SHALL have port pos  input  12  first character-cell address {row[4:0], col[6:0]}; one row is 128 cells.
REQ-008 SHALL have port fmt  input  1  0 = hex ("0x" + 4 digits, 6 chars); 1 = binary ("b" + 8 bits + SEP_CHAR + 8 bits, 18 chars).
REQ-009 SHALL have port busy  output  1  high while a request is being rendered.
REQ-010 SHALL have port done  output  1  one-cycle pulse when rendering completes.
REQ-011 SHALL have port wr_en  output  1  character-RAM write strobe.
REQ-012 SHALL have port wr_addr  output  12  character-cell address for the current write.
REQ-013 SHALL have port wr_char  output  8  ASCII code for the current write.

Function
REQ-014 SHALL implement states IDLE, WRITE and DONE.
REQ-015 SHALL, in IDLE with start=1, register value, pos and fmt, clear the character index to 0, and move to WRITE on the next edge.
REQ-016 SHALL, in WRITE, assert wr_en=1 every cycle, with wr_addr = (latched pos + index) mod 4096 and wr_char = the character at that index; index increments by 1 per cycle.
REQ-017 SHALL produce the hex sequence: "0", "x", then nibbles [15:12], [11:8], [7:4], [3:0], each as "0"+n for n<=9, otherwise "A"+n-10 (or "a"+n-10 when LOWERCASE_HEX=1).
REQ-018 SHALL produce the binary sequence: "b", bits 15..8 each as "0"+bit, SEP_CHAR, then bits 7..0.
REQ-019 SHALL leave WRITE after the last character (index 5 for hex, 17 for binary), go to DONE for exactly one cycle with done=1 and wr_en=0, then return to IDLE.
REQ-020 SHALL hold busy=1 in WRITE and DONE, and busy=0 in IDLE.
REQ-021 SHALL have the following latency, with the start-accepting edge as cycle 0: first write in cycle 1; done in cycle 7 (hex) or cycle 19 (binary); a new start is accepted in cycle 8 or cycle 20.
REQ-022 SHALL ignore start while busy=1; the request in progress is unaffected and is neither queued nor aborted.
REQ-023 SHALL not propagate changes of value, pos or fmt made after acceptance into the request in progress.
REQ-024 SHALL let addresses wrap modulo 4096; a column overflow carries into the row field, and row 31 col 127 + 1 gives address 0.
REQ-025 SHALL drive wr_en=0 in IDLE and DONE, and hold wr_addr and wr_char at their last driven values there.

Reset
REQ-026 SHALL, while reset=0, force state=IDLE, busy=0, done=0, wr_en=0, wr_addr=0, wr_char=8'h20, index=0, and clear all latched inputs, regardless of clk.
REQ-027 SHALL, on reset assertion mid-render, drop the remaining writes with no done pulse; the first start after reset release is accepted normally.

Verification
REQ-028 SHALL pass: hex, value=16'hCAFE, pos=12'd1553, LOWERCASE_HEX=0 -> writes "0","x","C","A","F","E" at 1553..1558 in cycles 1-6; done in cycle 7.
REQ-029 SHALL pass: binary, value=16'h1234, pos=12'd1714 -> 18 writes at 1714..1731, "b00010010_00110100"; done in cycle 19; busy high in cycles 1-19.
REQ-030 SHALL pass: hex, value=16'h00A9, pos=12'hFFE, LOWERCASE_HEX=1 -> addresses FFE, FFF, 000, 001, 002, 003 with "0","x","0","0","a","9".
REQ-031 SHALL pass: start pulsed in cycle 3 of a hex render with different value and pos -> ignored; original 6 writes complete unchanged and exactly one done pulse occurs.
REQ-032 SHALL pass: reset driven low between edges during cycle 4 of a binary render -> wr_en, busy and done go 0 immediately with no further writes; a hex start after release produces a correct full render.

Source files
------------

// File: rtl/value_text_writer_if.sv
// Bus bundle for value_text_writer: render request inputs and character-RAM write outputs.
interface value_text_writer_if;
   logic        start;
   logic [15:0] value;
   logic [11:0] pos;
   logic        fmt;
   logic        busy;
   logic        done;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [7:0]  wr_char;

   modport master (
      output start, value, pos, fmt,
      input  busy, done, wr_en, wr_addr, wr_char
   );

   modport slave (
      input  start, value, pos, fmt,
      output busy, done, wr_en, wr_addr, wr_char
   );
endinterface

// File: rtl/value_text_writer.sv
// Renders a 16-bit value as ASCII text ("0xHHHH" or "bXXXXXXXX_XXXXXXXX") into a
// character RAM, one character per cycle, starting at a given cell address.
// All outputs are registered; they reflect the state the FSM was in one edge earlier,
// so the first write appears one cycle after the start is accepted.
module value_text_writer #(
   parameter bit         LOWERCASE_HEX = 1'b0,
   parameter logic [7:0] SEP_CHAR      = 8'h5F
) (
   input logic          clk,
   input logic          reset,
   value_text_writer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state;
   logic [4:0]  index;
   logic [15:0] latched_value;
   logic [11:0] latched_pos;
   logic        latched_fmt;
   logic        busy;
   logic        done;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [7:0]  wr_char;

   // ASCII for a single hex nibble, honouring the letter-case parameter.
   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      logic [7:0] ch;
      if (nib <= 4'd9) begin
         ch = 8'h30 + {4'h0, nib};
      end else begin
         ch = (LOWERCASE_HEX ? 8'h61 : 8'h41) + {4'h0, nib} - 8'd10;
      end
      return ch;
   endfunction

   // ASCII "0" or "1" for one bit.
   function automatic logic [7:0] bit_char(input logic b);
      return b ? 8'h31 : 8'h30;
   endfunction

   // Character at position idx of the rendered text.
   // Binary bit select: idx 1..8 map to bits 15..8 (16 - idx) and idx 10..17 map to
   // bits 7..0 (17 - idx); both are computed modulo 16 on the low index bits.
   function automatic logic [7:0] char_at(input logic [4:0] idx,
                                          input logic [15:0] v,
                                          input logic f);
      logic [7:0] ch;
      logic [3:0] sel;
      ch  = 8'h20;
      sel = 4'd0;
      if (f == 1'b0) begin
         case (idx)
            5'd0:    ch = 8'h30;
            5'd1:    ch = 8'h78;
            5'd2:    ch = hex_char(v[15:12]);
            5'd3:    ch = hex_char(v[11:8]);
            5'd4:    ch = hex_char(v[7:4]);
            5'd5:    ch = hex_char(v[3:0]);
            default: ch = 8'h20;
         endcase
      end else begin
         if (idx == 5'd0) begin
            ch = 8'h62;
         end else if (idx == 5'd9) begin
            ch = SEP_CHAR;
         end else if (idx <= 5'd8) begin
            sel = 4'd0 - idx[3:0];
            ch  = bit_char(v[sel]);
         end else begin
            sel = 4'd1 - idx[3:0];
            ch  = bit_char(v[sel]);
         end
      end
      return ch;
   endfunction

   // Render FSM: accepts a request in IDLE, emits one character per cycle in WRITE,
   // pulses done from DONE, and keeps the write bus at its last value when idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         index         <= 5'd0;
         latched_value <= 16'd0;
         latched_pos   <= 12'd0;
         latched_fmt   <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         wr_en         <= 1'b0;
         wr_addr       <= 12'd0;
         wr_char       <= 8'h20;
      end else begin
         case (state)
            IDLE: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               wr_en <= 1'b0;
               if (bus.start) begin
                  latched_value <= bus.value;
                  latched_pos   <= bus.pos;
                  latched_fmt   <= bus.fmt;
                  index         <= 5'd0;
                  state         <= WRITE;
               end
            end
            WRITE: begin
               busy    <= 1'b1;
               done    <= 1'b0;
               wr_en   <= 1'b1;
               wr_addr <= latched_pos + {7'd0, index};
               wr_char <= char_at(index, latched_value, latched_fmt);
               index   <= index + 5'd1;
               if (index == (latched_fmt ? 5'd17 : 5'd5)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b1;
               done  <= 1'b1;
               wr_en <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               wr_en <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = busy;
   assign bus.done    = done;
   assign bus.wr_en   = wr_en;
   assign bus.wr_addr = wr_addr;
   assign bus.wr_char = wr_char;

endmodule

// File: tb/tb_value_text_writer.sv
// Bench for value_text_writer: two instances (upper- and lower-case hex) driven with
// identical stimulus; expected writes are queued per instance and compared as they occur.
module tb_value_text_writer;

   logic clk;
   logic reset;

   value_text_writer_if bu ();
   value_text_writer_if bl ();

   assign bl.start = bu.start;
   assign bl.value = bu.value;
   assign bl.pos   = bu.pos;
   assign bl.fmt   = bu.fmt;

   value_text_writer #(.LOWERCASE_HEX(1'b0), .SEP_CHAR(8'h5F)) dut_u (
      .clk(clk), .reset(reset), .bus(bu)
   );
   value_text_writer #(.LOWERCASE_HEX(1'b1), .SEP_CHAR(8'h5F)) dut_l (
      .clk(clk), .reset(reset), .bus(bl)
   );

   typedef struct packed {
      logic [11:0] addr;
      logic [7:0]  ch;
   } wr_t;

   typedef struct {
      logic        fmt;
      logic [15:0] value;
      logic [11:0] pos;
      logic [143:0] text_u;
      logic [143:0] text_l;
      int          done_cycle;
   } vec_t;

   wr_t  q_u[$];
   wr_t  q_l[$];
   vec_t vecs[7];
   int   checks   = 0;
   int   failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Queue the expected (address, character) stream of one render for both instances.
   task automatic push_exp(input logic [11:0] pos, input logic [143:0] tu,
                           input logic [143:0] tl, input int len);
      wr_t e;
      for (int i = 0; i < len; i++) begin
         e.addr = pos + 12'(i);
         e.ch   = tu[(len - 1 - i) * 8 +: 8];
         q_u.push_back(e);
         e.ch   = tl[(len - 1 - i) * 8 +: 8];
         q_l.push_back(e);
      end
   endtask

   // Scoreboard for the upper-case instance.
   always @(negedge clk) begin
      wr_t e;
      if (bu.wr_en === 1'b1) begin
         if (q_u.size() == 0) begin
            check("unexpected_write_u", int'(bu.wr_addr), -1);
         end else begin
            e = q_u.pop_front();
            check("wr_addr_u", int'(bu.wr_addr), int'(e.addr));
            check("wr_char_u", int'(bu.wr_char), int'(e.ch));
         end
      end
   end

   // Scoreboard for the lower-case instance.
   always @(negedge clk) begin
      wr_t e;
      if (bl.wr_en === 1'b1) begin
         if (q_l.size() == 0) begin
            check("unexpected_write_l", int'(bl.wr_addr), -1);
         end else begin
            e = q_l.pop_front();
            check("wr_addr_l", int'(bl.wr_addr), int'(e.addr));
            check("wr_char_l", int'(bl.wr_char), int'(e.ch));
         end
      end
   end

   // One render; mode 1 also pulses a conflicting start in cycle 3 that must be ignored.
   task automatic run_vec(input vec_t v, input int mode);
      int len;
      int e_wren;
      int e_busy;
      int e_done;
      int n_done;
      logic x_wren;
      logic x_busy;
      logic x_done;
      len    = v.fmt ? 18 : 6;
      e_wren = 0;
      e_busy = 0;
      e_done = 0;
      n_done = 0;
      @(negedge clk);
      bu.start = 1'b1;
      bu.value = v.value;
      bu.pos   = v.pos;
      bu.fmt   = v.fmt;
      push_exp(v.pos, v.text_u, v.text_l, len);
      @(posedge clk);
      #1;
      bu.start = 1'b0;
      bu.value = 16'($urandom);
      bu.pos   = 12'($urandom);
      bu.fmt   = ~v.fmt;
      for (int c = 0; c <= v.done_cycle + 3; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         if (mode == 1 && c == 3) begin
            bu.start = 1'b1;
            bu.value = 16'h5555;
            bu.pos   = 12'd7;
            bu.fmt   = 1'b0;
         end
         if (mode == 1 && c == 4) bu.start = 1'b0;
         x_wren = (c >= 1 && c <= len);
         x_busy = (c >= 1 && c <= len + 1);
         x_done = (c == v.done_cycle);
         if (bu.wr_en !== x_wren || bl.wr_en !== x_wren) e_wren++;
         if (bu.busy  !== x_busy || bl.busy  !== x_busy) e_busy++;
         if (bu.done  !== x_done || bl.done  !== x_done) e_done++;
         if (bu.done === 1'b1) n_done++;
      end
      check("wren_seq", e_wren, 0);
      check("busy_seq", e_busy, 0);
      check("done_seq", e_done, 0);
      check("done_count", n_done, 1);
      check("sb_drain_u", q_u.size(), 0);
      check("sb_drain_l", q_l.size(), 0);
   endtask

   initial begin
      int n_done;
      vecs[0] = '{1'b0, 16'hCAFE, 12'd1553, 144'("0xCAFE"), 144'("0xcafe"), 7};
      vecs[1] = '{1'b1, 16'h1234, 12'd1714, 144'("b00010010_00110100"),
                  144'("b00010010_00110100"), 19};
      vecs[2] = '{1'b0, 16'h00A9, 12'hFFE, 144'("0x00A9"), 144'("0x00a9"), 7};
      vecs[3] = '{1'b1, 16'hFFFF, 12'hFF8, 144'("b11111111_11111111"),
                  144'("b11111111_11111111"), 19};
      vecs[4] = '{1'b0, 16'h0000, 12'd0, 144'("0x0000"), 144'("0x0000"), 7};
      vecs[5] = '{1'b0, 16'h9F3B, 12'd127, 144'("0x9F3B"), 144'("0x9f3b"), 7};
      vecs[6] = '{1'b1, 16'h8001, 12'd100, 144'("b10000000_00000001"),
                  144'("b10000000_00000001"), 19};

      reset    = 1'b0;
      bu.start = 1'b0;
      bu.value = 16'd0;
      bu.pos   = 12'd0;
      bu.fmt   = 1'b0;
      #12;
      check("rst_busy", int'(bu.busy), 0);
      check("rst_done", int'(bu.done), 0);
      check("rst_wr_en", int'(bu.wr_en), 0);
      check("rst_wr_addr", int'(bu.wr_addr), 0);
      check("rst_wr_char", int'(bu.wr_char), 32'h20);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], 0);

      // Conflicting start while busy is ignored.
      run_vec(vecs[0], 1);

      // Start held high: second request accepted exactly when the first has finished.
      @(negedge clk);
      bu.start = 1'b1;
      bu.value = 16'hBEEF;
      bu.pos   = 12'd500;
      bu.fmt   = 1'b0;
      push_exp(12'd500, 144'("0xBEEF"), 144'("0xbeef"), 6);
      push_exp(12'd40, 144'("0x0F0F"), 144'("0x0f0f"), 6);
      @(posedge clk);
      #1;
      bu.value = 16'h0F0F;
      bu.pos   = 12'd40;
      n_done   = 0;
      for (int c = 1; c <= 18; c++) begin
         @(posedge clk);
         #1;
         if (c == 8) bu.start = 1'b0;
         if (bu.done === 1'b1) n_done++;
         if (c == 9) begin
            check("b2b_wr_en", int'(bu.wr_en), 1);
            check("b2b_first_addr", int'(bu.wr_addr), 40);
         end
         if (c == 15) check("b2b_done_c15", int'(bu.done), 1);
      end
      check("b2b_done_count", n_done, 2);
      check("b2b_drain_u", q_u.size(), 0);

      // Reset between edges during cycle 4 of a binary render.
      @(negedge clk);
      bu.start = 1'b1;
      bu.value = 16'hA5C3;
      bu.pos   = 12'd300;
      bu.fmt   = 1'b1;
      push_exp(12'd300, 144'("b10100101_11000011"), 144'("b10100101_11000011"), 18);
      @(posedge clk);
      #1;
      bu.start = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      #2;
      reset = 1'b0;
      #1;
      check("arst_wr_en", int'(bu.wr_en), 0);
      check("arst_busy", int'(bu.busy), 0);
      check("arst_done", int'(bu.done), 0);
      check("arst_wr_addr", int'(bu.wr_addr), 0);
      check("arst_wr_char", int'(bu.wr_char), 32'h20);
      check("arst_wr_en_l", int'(bl.wr_en), 0);
      q_u.delete();
      q_l.delete();
      repeat (3) @(posedge clk);
      #1;
      check("arst_hold_busy", int'(bu.busy), 0);
      @(negedge clk);
      reset = 1'b1;
      run_vec(vecs[2], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
